// File: rtl/completer_pkg.sv
// Shared types for the burst completer: burst addressing modes and FSM states.
package completer_pkg;

   typedef enum logic [1:0] {
      FIXED   = 2'd0,
      UNIT    = 2'd1,
      STRIDED = 2'd2,
      RSVD    = 2'd3
   } burst_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } bc_state_e;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO. The head is read straight from storage, so data pushed
// on an edge is visible at the head in the following cycle. Pops on an empty FIFO
// and pushes on a full FIFO without a simultaneous pop are the caller's responsibility.
module resp_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Storage array; needs no reset since occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; a push and pop together leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/burst_completer.sv
// Burst memory completer: accepts one fixed/unit/strided burst at a time, issues
// reads under a credit limit that guarantees response FIFO space, and streams
// write beats straight through to the memory port.
module burst_completer
   import completer_pkg::*;
#(
   parameter int unsigned ADDR_W          = 15,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_LEN         = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned RESP_DEPTH      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_wr,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [$clog2(MAX_LEN):0]   cmd_len,
   input  logic [1:0]                 cmd_mode,
   input  logic [ADDR_W-1:0]          cmd_stride,
   input  logic                       wr,
   input  logic [DATA_W-1:0]          wrdata,
   output logic                       ready,
   output logic [DATA_W-1:0]          rddata,
   output logic                       rddatavalid,
   input  logic                       rddataready,
   output logic                       mem_valid_rd,
   output logic                       mem_valid_wr,
   output logic [31:0]                mem_address,
   output logic [DATA_W-1:0]          mem_data_wr,
   input  logic                       mem_ready,
   input  logic                       mem_valid_o,
   input  logic [DATA_W-1:0]          mem_data_o,
   output logic                       busy,
   output logic                       err
);

   localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;
   localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned CNT_W   = $clog2(RESP_DEPTH + 1);
   localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);

   bc_state_e         state;
   bc_state_e         state_nx;
   burst_mode_e       mode_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issue_cnt;
   logic [LEN_W-1:0]  deliver_cnt;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] beat_addr;
   logic [ADDR_W-1:0] addr_step;
   logic [OUT_W-1:0]  outstanding;
   logic              err_q;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   logic cmd_accept;
   logic rd_credit;
   logic rd_issue;
   logic wr_beat;
   logic resp_take;
   logic resp_drop;
   logic fifo_pop;

   assign cmd_accept = cmd_valid & cmd_ready;
   assign rd_credit  = ((32'(outstanding) + 32'(fifo_count)) < 32'(RESP_DEPTH)) &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING));
   assign rd_issue   = mem_valid_rd & mem_ready;
   assign wr_beat    = mem_valid_wr;
   assign resp_take  = mem_valid_o & (outstanding != '0);
   assign resp_drop  = mem_valid_o & (outstanding == '0);
   assign fifo_pop   = ~fifo_empty & rddataready;

   // Per-beat word address increment; the strided address is a running sum.
   always_comb begin
      addr_step = '0;
      case (mode_q)
         UNIT:    addr_step = ADDR_W'(1);
         STRIDED: addr_step = stride_q;
         default: addr_step = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake/memory-request outputs.
   always_comb begin
      state_nx     = state;
      cmd_ready    = 1'b0;
      ready        = 1'b0;
      mem_valid_rd = 1'b0;
      mem_valid_wr = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && (cmd_len != '0)) begin
               state_nx = cmd_wr ? WRITE : READ;
            end
         end
         WRITE: begin
            ready        = mem_ready;
            mem_valid_wr = wr & mem_ready;
            if (wr && mem_ready && (issue_cnt == len_q - 1'b1)) begin
               state_nx = IDLE;
            end
         end
         READ: begin
            mem_valid_rd = (issue_cnt < len_q) && rd_credit;
            if (fifo_pop && (deliver_cnt == len_q - 1'b1)) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command latch, beat counters, outstanding-read tracking and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= FIXED;
         len_q       <= '0;
         stride_q    <= '0;
         beat_addr   <= '0;
         issue_cnt   <= '0;
         deliver_cnt <= '0;
         outstanding <= '0;
         err_q       <= 1'b0;
      end else begin
         if (cmd_accept) begin
            mode_q      <= burst_mode_e'(cmd_mode);
            len_q       <= cmd_len;
            stride_q    <= cmd_stride;
            beat_addr   <= cmd_addr;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
         end else begin
            if (wr_beat || rd_issue) begin
               issue_cnt <= issue_cnt + 1'b1;
               beat_addr <= beat_addr + addr_step;
            end
            if (fifo_pop) begin
               deliver_cnt <= deliver_cnt + 1'b1;
            end
         end
         case ({rd_issue, resp_take})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (resp_drop) begin
            err_q <= 1'b1;
         end else if (cmd_accept) begin
            err_q <= 1'b0;
         end
      end
   end

   resp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RESP_DEPTH)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_take),
      .push_data (mem_data_o),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign mem_address = 32'(beat_addr) << BYTE_SH;
   assign mem_data_wr = wrdata;
   assign rddata      = fifo_head;
   assign rddatavalid = ~fifo_empty;
   assign busy        = (state != IDLE) | ~fifo_empty;
   assign err         = err_q;

endmodule

// File: tb/tb_burst_completer.sv
// Scoreboard bench for burst_completer: expected addresses/data are queued when a
// command is driven and popped as the DUT issues requests and delivers beats.
module tb_burst_completer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [14:0] cmd_addr;
   logic [5:0]  cmd_len;
   logic [1:0]  cmd_mode;
   logic [14:0] cmd_stride;
   logic        wr;
   logic [31:0] wrdata;
   logic        ready;
   logic [31:0] rddata;
   logic        rddatavalid;
   logic        rddataready;
   logic        mem_valid_rd;
   logic        mem_valid_wr;
   logic [31:0] mem_address;
   logic [31:0] mem_data_wr;
   logic        mem_ready;
   logic        mem_valid_o;
   logic [31:0] mem_data_o;
   logic        busy;
   logic        err;

   int compared   = 0;
   int mismatched = 0;
   int cyc = 0;
   int lat = 1;
   int n_rd, n_wr, n_del;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_rdata[$];
   logic [31:0] exp_wdata[$];
   int          mq_due[$];
   logic [31:0] mq_data[$];

   logic s_cmd_ready, s_ready, s_mvr, s_mvw, s_rdv, s_busy, s_err, s_mem_ready;

   burst_completer #(
      .ADDR_W          (15),
      .DATA_W          (32),
      .MAX_LEN         (32),
      .MAX_OUTSTANDING (4),
      .RESP_DEPTH      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_wr       (cmd_wr),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .cmd_mode     (cmd_mode),
      .cmd_stride   (cmd_stride),
      .wr           (wr),
      .wrdata       (wrdata),
      .ready        (ready),
      .rddata       (rddata),
      .rddatavalid  (rddatavalid),
      .rddataready  (rddataready),
      .mem_valid_rd (mem_valid_rd),
      .mem_valid_wr (mem_valid_wr),
      .mem_address  (mem_address),
      .mem_data_wr  (mem_data_wr),
      .mem_ready    (mem_ready),
      .mem_valid_o  (mem_valid_o),
      .mem_data_o   (mem_data_o),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h0001_9E37) ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] wdat(input int i);
      return 32'hD00D_0000 + 32'(i);
   endfunction

   // Reference byte address of beat i, computed directly from the beat index.
   function automatic logic [31:0] beat_byte(input logic [14:0] base, input int mode,
                                             input logic [14:0] stride, input int i);
      logic [14:0] w;
      case (mode)
         1:       w = base + 15'(i);
         2:       w = base + 15'(i * int'(stride));
         default: w = base;
      endcase
      return {15'b0, w, 2'b00};
   endfunction

   // One clock cycle: sample outputs mid-cycle, score traffic, then model memory responses.
   task automatic step();
      logic        fire;
      logic [31:0] a, e, d;
      #1;
      s_cmd_ready = cmd_ready;  s_ready = ready;  s_mvr = mem_valid_rd;  s_mvw = mem_valid_wr;
      s_rdv = rddatavalid;  s_busy = busy;  s_err = err;  s_mem_ready = mem_ready;
      compared++;
      if (mem_valid_rd && mem_valid_wr) begin
         mismatched++;
         $display("FAIL rd_wr_exclusive: got rd=1 wr=1 required not both");
      end
      fire = mem_valid_rd && mem_ready;
      if (fire) begin
         n_rd++;
         a = mem_address;
         mq_due.push_back(cyc + lat);
         mq_data.push_back(mem_fn(a));
         compared++;
         if (exp_addr.size() == 0) begin
            mismatched++;
            $display("FAIL rd_addr: got unexpected read to %h", a);
         end else begin
            e = exp_addr.pop_front();
            if (a !== e) begin
               mismatched++;
               $display("FAIL rd_addr: got %h required %h", a, e);
            end
         end
      end
      if (mem_valid_wr) begin
         n_wr++;
         compared++;
         if (exp_addr.size() == 0 || exp_wdata.size() == 0) begin
            mismatched++;
            $display("FAIL wr_beat: got unexpected write to %h", mem_address);
         end else begin
            e = exp_addr.pop_front();
            d = exp_wdata.pop_front();
            if (mem_address !== e || mem_data_wr !== d) begin
               mismatched++;
               $display("FAIL wr_beat: got %h/%h required %h/%h", mem_address, mem_data_wr, e, d);
            end
         end
      end
      if (rddatavalid && rddataready) begin
         n_del++;
         compared++;
         if (exp_rdata.size() == 0) begin
            mismatched++;
            $display("FAIL rd_data: got unexpected beat %h", rddata);
         end else begin
            d = exp_rdata.pop_front();
            if (rddata !== d) begin
               mismatched++;
               $display("FAIL rd_data: got %h required %h", rddata, d);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         mem_valid_o = 1'b1;
         mem_data_o  = mq_data.pop_front();
         void'(mq_due.pop_front());
      end else begin
         mem_valid_o = 1'b0;
         mem_data_o  = '0;
      end
   endtask

   task automatic send_cmd(input bit w, input logic [14:0] addr, input int len,
                           input int mode, input logic [14:0] stride);
      cmd_valid  = 1'b1;
      cmd_wr     = w;
      cmd_addr   = addr;
      cmd_len    = 6'(len);
      cmd_mode   = 2'(mode);
      cmd_stride = stride;
      for (int i = 0; i < len; i++) begin
         exp_addr.push_back(beat_byte(addr, mode, stride, i));
         if (w) exp_wdata.push_back(wdat(i));
         else   exp_rdata.push_back(mem_fn(beat_byte(addr, mode, stride, i)));
      end
      step();
      cmd_valid = 1'b0;
      compared++;
      if (s_cmd_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL cmd_accept: got cmd_ready=%b required 1", s_cmd_ready);
      end
   endtask

   task automatic run_idle(input int maxc, input bit rnd);
      bit done = 1'b0;
      for (int k = 0; k < maxc && !done; k++) begin
         if (rnd) rddataready = 1'($urandom_range(0, 1));
         step();
         if (!s_busy && exp_rdata.size() == 0 && exp_addr.size() == 0) done = 1'b1;
      end
      rddataready = 1'b1;
      compared++;
      if (!done) begin
         mismatched++;
         $display("FAIL burst_timeout: got busy=%b pending=%0d required idle", s_busy, exp_addr.size());
      end
   endtask

   task automatic check_outputs_reset(input string tag);
      compared++;
      if ({cmd_ready, ready, rddatavalid, mem_valid_rd, mem_valid_wr, busy, err} !== 7'b1000000) begin
         mismatched++;
         $display("FAIL %s: got rdy/ready/rdv/mvr/mvw/busy/err=%b%b%b%b%b%b%b required 1000000", tag,
                  cmd_ready, ready, rddatavalid, mem_valid_rd, mem_valid_wr, busy, err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;  cmd_valid = 1'b0;  cmd_wr = 1'b0;  cmd_addr = '0;  cmd_len = '0;
      cmd_mode = '0;  cmd_stride = '0;  wr = 1'b0;  wrdata = '0;  rddataready = 1'b1;
      mem_ready = 1'b1;  mem_valid_o = 1'b0;  mem_data_o = '0;
      step();
      step();
      check_outputs_reset("reset_values");
      rst = 1'b0;
      step();
      check_outputs_reset("after_reset_release");
   endtask

   task automatic test_unit_read();
      n_rd = 0;  n_del = 0;  lat = 1;
      send_cmd(1'b0, 15'h0010, 4, 1, 15'h0);
      step();
      compared++;
      if (s_mvr !== 1'b1) begin
         mismatched++;
         $display("FAIL first_rd_latency: got mem_valid_rd=%b required 1", s_mvr);
      end
      run_idle(100, 1'b0);
      compared++;
      if (n_rd !== 4 || n_del !== 4) begin
         mismatched++;
         $display("FAIL unit_read_count: got %0d issued %0d delivered required 4 4", n_rd, n_del);
      end
   endtask

   task automatic test_strided_wrap();
      n_del = 0;
      send_cmd(1'b0, 15'h7FFE, 3, 2, 15'h0003);
      run_idle(100, 1'b1);
      compared++;
      if (n_del !== 3) begin
         mismatched++;
         $display("FAIL strided_count: got %0d required 3", n_del);
      end
   endtask

   task automatic test_backpressure();
      n_rd = 0;  n_del = 0;  rddataready = 1'b0;
      send_cmd(1'b0, 15'h0200, 16, 1, 15'h0);
      repeat (30) step();
      compared++;
      if (n_rd !== 8 || s_mvr !== 1'b0 || s_rdv !== 1'b1 || n_del !== 0) begin
         mismatched++;
         $display("FAIL credit_stall: got issued=%0d mvr=%b rdv=%b del=%0d required 8 0 1 0",
                  n_rd, s_mvr, s_rdv, n_del);
      end
      rddataready = 1'b1;
      run_idle(200, 1'b0);
      compared++;
      if (n_rd !== 16 || n_del !== 16) begin
         mismatched++;
         $display("FAIL backpressure_drain: got %0d issued %0d delivered required 16 16", n_rd, n_del);
      end
   endtask

   task automatic test_write();
      int k = 0;
      bit tog = 1'b1;
      n_wr = 0;
      send_cmd(1'b1, 15'h0123, 5, 0, 15'h0);
      for (int g = 0; g < 40 && k < 5; g++) begin
         mem_ready = tog;
         wr        = 1'b1;
         wrdata    = wdat(k);
         step();
         compared++;
         if (s_ready !== s_mem_ready) begin
            mismatched++;
            $display("FAIL ready_track: got ready=%b required %b", s_ready, s_mem_ready);
         end
         if (s_ready) k++;
         tog = ~tog;
      end
      wr = 1'b0;
      mem_ready = 1'b1;
      send_cmd(1'b0, 15'h0000, 0, 0, 15'h0);
      step();
      compared++;
      if (n_wr !== 5 || exp_addr.size() != 0 || s_busy !== 1'b0) begin
         mismatched++;
         $display("FAIL write_burst: got %0d writes busy=%b left=%0d required 5 0 0",
                  n_wr, s_busy, exp_addr.size());
      end
   endtask

   task automatic test_zero_len_and_err();
      n_rd = 0;  n_wr = 0;
      send_cmd(1'b0, 15'h0055, 0, 1, 15'h0);
      repeat (3) step();
      compared++;
      if (n_rd !== 0 || n_wr !== 0 || s_cmd_ready !== 1'b1 || s_busy !== 1'b0) begin
         mismatched++;
         $display("FAIL zero_len: got rd=%0d wr=%0d cmd_ready=%b busy=%b required 0 0 1 0",
                  n_rd, n_wr, s_cmd_ready, s_busy);
      end
      mem_valid_o = 1'b1;
      mem_data_o  = 32'hDEAD_BEEF;
      step();
      step();
      compared++;
      if (s_err !== 1'b1 || s_rdv !== 1'b0) begin
         mismatched++;
         $display("FAIL spurious_resp: got err=%b rdv=%b required 1 0", s_err, s_rdv);
      end
      send_cmd(1'b0, 15'h0000, 0, 0, 15'h0);
      step();
      compared++;
      if (s_err !== 1'b0) begin
         mismatched++;
         $display("FAIL err_clear: got err=%b required 0", s_err);
      end
   endtask

   task automatic test_reset_midburst();
      n_rd = 0;  n_del = 0;  lat = 10;  rddataready = 1'b1;
      send_cmd(1'b0, 15'h0300, 8, 1, 15'h0);
      for (int g = 0; g < 20 && n_rd < 3; g++) step();
      compared++;
      if (n_rd !== 3) begin
         mismatched++;
         $display("FAIL midburst_setup: got %0d issued required 3", n_rd);
      end
      rst = 1'b1;
      #1;
      check_outputs_reset("async_reset_midburst");
      exp_addr.delete();  exp_rdata.delete();  mq_due.delete();  mq_data.delete();
      mem_valid_o = 1'b0;
      #1;
      rst = 1'b0;
      lat = 2;  n_rd = 0;  n_del = 0;
      send_cmd(1'b0, 15'h0040, 6, 2, 15'h0005);
      run_idle(150, 1'b1);
      compared++;
      if (n_del !== 6 || s_err !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_burst: got %0d delivered err=%b required 6 0", n_del, s_err);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_unit_read();
      test_strided_wrap();
      test_backpressure();
      test_write();
      test_zero_len_and_err();
      test_reset_midburst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
